// File: rtl/nios_system_keys_in.sv
// Avalon-MM input PIO: synchronises and debounces external keys, exposes a 4-word register map,
// captures per-bit edges and raises a maskable level interrupt.
module nios_system_keys_in #(
    parameter int WIDTH     = 8,
    parameter int DEBOUNCE  = 4,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_RSVD  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    typedef enum logic {
        PRIME,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         prime_q, prime_d;
    logic [WIDTH-1:0]   s1_q, s2_q;
    logic [WIDTH-1:0]   db_q, db_d;
    logic [CW-1:0]      cnt_q [WIDTH];
    logic [CW-1:0]      cnt_d [WIDTH];
    logic [WIDTH-1:0]   irqmask_q, irqmask_d;
    logic [WIDTH-1:0]   edgecap_q, edgecap_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               wr_en;
    logic [WIDTH-1:0]   wr_bits;
    logic [WIDTH-1:0]   clr_bits;
    logic [WIDTH-1:0]   edge_ev;
    logic               unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Debounce and state sequencing. PRIME loads db straight from the synchroniser for long
    // enough that inputs held through reset are seen as the starting level, not as edges.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        prime_d = prime_q;
        db_d    = db_q;
        cnt_d   = cnt_q;

        if (state_q == PRIME) begin
            db_d = s2_q;
            for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
            if (prime_q == 2'd2) state_d = RUN;
            else                 prime_d = prime_q + 2'd1;
        end else if (DEBOUNCE == 0) begin
            db_d = s2_q;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Edge capture and register writes; a new edge on a bit beats a same-cycle clear.
    always_comb begin
        edge_ev = '0;
        if (state_q == RUN) begin
            case (EDGE_TYPE)
                0:       edge_ev = db_d & ~db_q;
                1:       edge_ev = ~db_d & db_q;
                default: edge_ev = db_d ^ db_q;
            endcase
        end

        clr_bits  = (wr_en && address == ADDR_EDGE) ? wr_bits : '0;
        irqmask_d = (wr_en && address == ADDR_MASK) ? wr_bits : irqmask_q;
        edgecap_d = (edgecap_q & ~clr_bits) | edge_ev;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(db_q);
            ADDR_RSVD: readdata_d = '0;
            ADDR_MASK: readdata_d = 32'(irqmask_q);
            ADDR_EDGE: readdata_d = 32'(edgecap_q);
            default:   readdata_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PRIME;
            prime_q    <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            // NOTE: the per-bit counter array is small and must restart at zero, so it is reset.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            prime_q    <= prime_d;
            s1_q       <= in_port;
            s2_q       <= s1_q;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_system_keys_in.sv
// Directed bench: one debounced rising-edge instance and one undebounced falling-edge
// instance share the bus; expected values are worked out by hand per step.
module tb_nios_system_keys_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a, in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;
    logic [31:0] va, vb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios_system_keys_in #(.WIDTH(8), .DEBOUNCE(4), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    nios_system_keys_in #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step(1);
        da         = rd_a;
        db         = rd_b;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_a       = 8'hFF;
        in_b       = 8'hF7;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #1;
        check("reset_readdata", rd_a, 32'h0);
        check("reset_irq", {31'b0, irq_a}, 32'h0);
        step(3);
        reset_n = 1'b1;
        step(10);

        // Inputs held high through reset produce no edge.
        bus_read(2'd0, va, vb);
        check("t1_data_a", va, 32'h0000_00FF);
        check("t1_data_b", vb, 32'h0000_00F7);
        bus_read(2'd3, va, vb);
        check("t1_edge_a", va, 32'h0);
        check("t1_edge_b", vb, 32'h0);
        check("t1_irq_a", {31'b0, irq_a}, 32'h0);

        // Debounce: 3-cycle glitch rejected, long hold accepted.
        in_a = 8'hFE;
        step(10);
        bus_read(2'd0, va, vb);
        check("t2_data_low", va, 32'h0000_00FE);
        in_a = 8'hFF;
        step(3);
        in_a = 8'hFE;
        step(10);
        bus_read(2'd0, va, vb);
        check("t2_glitch_data", va, 32'h0000_00FE);
        bus_read(2'd3, va, vb);
        check("t2_glitch_edge", va, 32'h0);
        in_a = 8'hFF;
        step(10);
        bus_read(2'd0, va, vb);
        check("t2_held_data", va, 32'h0000_00FF);
        bus_read(2'd3, va, vb);
        check("t2_held_edge", va, 32'h0000_0001);

        // Masked interrupt and write-1-to-clear.
        bus_write(2'd2, 32'h1);
        check("t3_irq_set", {31'b0, irq_a}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("t3_irq_clr", {31'b0, irq_a}, 32'h0);
        bus_read(2'd3, va, vb);
        check("t3_edge_clr", va, 32'h0);

        // Edge on bit2 lands on the same clock as a clear of bit2: set wins.
        in_a = 8'hFB;
        step(10);
        bus_read(2'd3, va, vb);
        check("t4_fall_no_edge", va, 32'h0);
        in_a = 8'hFF;
        step(5);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, va, vb);
        check("t4_set_wins", va, 32'h0000_0004);
        check("t4_irq_masked", {31'b0, irq_a}, 32'h0);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, va, vb);
        check("t4_clear_after", va, 32'h0);

        // irqmask readback; a write without chipselect is ignored.
        bus_write(2'd2, 32'hFFFF_FF5A);
        bus_read(2'd2, va, vb);
        check("mask_readback", va, 32'h0000_005A);
        address    = 2'd2;
        writedata  = 32'hFF;
        write_n    = 1'b0;
        chipselect = 1'b0;
        step(1);
        write_n    = 1'b1;
        bus_read(2'd2, va, vb);
        check("mask_no_cs", va, 32'h0000_005A);
        bus_write(2'd2, 32'h0);

        // Undebounced falling-edge instance: db latency, rising ignored, falling captured.
        address    = 2'd0;
        chipselect = 1'b1;
        in_b       = 8'hFF;
        step(3);
        check("t5_lat_before", rd_b, 32'h0000_00F7);
        step(1);
        check("t5_lat_after", rd_b, 32'h0000_00FF);
        chipselect = 1'b0;
        bus_read(2'd3, va, vb);
        check("t5_rise_ignored", vb, 32'h0);
        in_b = 8'hF7;
        step(5);
        bus_read(2'd3, va, vb);
        check("t5_fall_edge", vb, 32'h0000_0008);
        check("t5_irq_unmasked0", {31'b0, irq_b}, 32'h0);
        bus_write(2'd2, 32'h8);
        check("t5_irq_masked_on", {31'b0, irq_b}, 32'h1);
        bus_write(2'd2, 32'h0);

        // Reserved address reads zero; data register ignores writes.
        bus_read(2'd1, va, vb);
        check("t6_rsvd", va, 32'h0);
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'hFF);
        bus_read(2'd0, va, vb);
        check("t6_data_a", va, 32'h0000_00FF);
        bus_write(2'd0, 32'hFF);
        bus_read(2'd0, va, vb);
        check("t6_data_b", vb, 32'h0000_00F7);

        // Reset mid-operation clears state asynchronously.
        in_a = 8'hFE;
        step(10);
        in_a = 8'hFF;
        step(10);
        bus_write(2'd2, 32'h1);
        check("rst_irq_pre", {31'b0, irq_a}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_irq_async", {31'b0, irq_a}, 32'h0);
        check("rst_rd_async", rd_a, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(10);
        bus_read(2'd3, va, vb);
        check("rst_edge_after", va, 32'h0);
        bus_read(2'd2, va, vb);
        check("rst_mask_after", va, 32'h0);
        bus_read(2'd0, va, vb);
        check("rst_data_after", va, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
